// File: rtl/fan_pwm_tach_ctrl.sv
// Multi-channel fan controller: shared-period glitch-free PWM with ramped duty,
// windowed tach edge counting, sticky stall detection and full-speed failsafe.
module fan_pwm_tach_ctrl #(
    parameter int unsigned NUM_FANS     = 3,
    parameter int unsigned DUTY_W       = 8,
    parameter int unsigned PERIOD       = 222,
    parameter int unsigned RST_DUTY     = 150,
    parameter int unsigned MIN_DUTY     = 40,
    parameter int unsigned RAMP_DIV     = 4,
    parameter int unsigned RAMP_STEP    = 2,
    parameter int unsigned TACH_W       = 16,
    parameter int unsigned TACH_WIN     = 7812500,
    parameter int unsigned STALL_MIN    = 2,
    parameter int unsigned FAIL_WINDOWS = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_FANS*DUTY_W-1:0]   duty_target,
    input  logic                         duty_load,
    input  logic                         force_full,
    input  logic                         fail_clr,
    input  logic [NUM_FANS-1:0]          tach_in,
    output logic [NUM_FANS-1:0]          pwm_out,
    output logic [NUM_FANS*DUTY_W-1:0]   duty_cur,
    output logic [NUM_FANS*TACH_W-1:0]   tach_count,
    output logic                         tach_valid,
    output logic [NUM_FANS-1:0]          fan_fail
);
    localparam logic [DUTY_W-1:0] P_D    = DUTY_W'(PERIOD);
    localparam logic [DUTY_W-1:0] MIN_D  = DUTY_W'(MIN_DUTY);
    localparam logic [DUTY_W-1:0] STEP_D = DUTY_W'(RAMP_STEP);
    // A reset target above PERIOD behaves exactly like PERIOD, so store it clamped.
    localparam logic [DUTY_W-1:0] RST_D  = DUTY_W'((RST_DUTY > PERIOD) ? PERIOD : RST_DUTY);
    localparam int unsigned WCW = (TACH_WIN > 1) ? $clog2(TACH_WIN) : 1;
    localparam int unsigned RDW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int unsigned LCW = $clog2(FAIL_WINDOWS + 1);

    function automatic logic [DUTY_W-1:0] clamp_tgt(input logic [DUTY_W-1:0] t);
        if (t == '0)         return '0;
        else if (t < MIN_D)  return MIN_D;
        else if (t > P_D)    return P_D;
        else                 return t;
    endfunction

    // One ramp step; never crosses the target and never rests between 0 and MIN_DUTY.
    function automatic logic [DUTY_W-1:0] ramp_step(input logic [DUTY_W-1:0] cur,
                                                     input logic [DUTY_W-1:0] tgt);
        if (cur == tgt)                             return cur;
        else if (cur < tgt) begin
            if (cur == '0)                          return (tgt < MIN_D) ? tgt : MIN_D;
            else if (tgt - cur <= STEP_D)           return tgt;
            else                                    return cur + STEP_D;
        end else begin
            if (tgt == '0 && cur <= MIN_D)          return '0;
            else if (cur - tgt <= STEP_D)           return tgt;
            else if (tgt == '0 && cur - STEP_D < MIN_D) return MIN_D;
            else                                    return cur - STEP_D;
        end
    endfunction

    logic [DUTY_W-1:0] r_pcnt;
    logic [RDW-1:0]    r_rdiv;
    logic [WCW-1:0]    r_wcnt;
    logic [NUM_FANS-1:0] r_pwm, r_s1, r_s2, r_s3, r_fail;
    logic              r_tvalid;
    logic [DUTY_W-1:0] r_duty [NUM_FANS];
    logic [DUTY_W-1:0] r_tgt  [NUM_FANS];
    logic [TACH_W-1:0] r_ecnt [NUM_FANS];
    logic [TACH_W-1:0] r_tcnt [NUM_FANS];
    logic [LCW-1:0]    r_low  [NUM_FANS];

    logic              w_bnd, w_rstep, w_wend;
    logic [NUM_FANS-1:0] w_edge;
    logic [TACH_W-1:0] w_fin  [NUM_FANS];

    assign w_bnd   = (r_pcnt == DUTY_W'(PERIOD - 1));
    assign w_rstep = (r_rdiv == RDW'(RAMP_DIV - 1));
    assign w_wend  = (r_wcnt == WCW'(TACH_WIN - 1));
    assign w_edge  = r_s2 & ~r_s3;

    // Closing count includes an edge landing on the window's last cycle.
    always_comb begin
        for (int unsigned i = 0; i < NUM_FANS; i++) begin
            w_fin[i] = (r_ecnt[i] == '1) ? r_ecnt[i] : r_ecnt[i] + TACH_W'(w_edge[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pcnt   <= '0;
            r_rdiv   <= '0;
            r_wcnt   <= '0;
            r_pwm    <= '0;
            r_s1     <= '0;
            r_s2     <= '0;
            r_s3     <= '0;
            r_fail   <= '0;
            r_tvalid <= 1'b0;
            for (int unsigned i = 0; i < NUM_FANS; i++) begin
                r_duty[i] <= RST_D;
                r_tgt[i]  <= RST_D;
                r_ecnt[i] <= '0;
                r_tcnt[i] <= '0;
                r_low[i]  <= '0;
            end
        end else begin
            r_pcnt   <= w_bnd ? '0 : r_pcnt + 1'b1;
            r_wcnt   <= w_wend ? '0 : r_wcnt + 1'b1;
            r_tvalid <= w_wend;
            r_s1     <= tach_in;
            r_s2     <= r_s1;
            r_s3     <= r_s2;
            if (w_bnd) r_rdiv <= w_rstep ? '0 : r_rdiv + 1'b1;

            for (int unsigned i = 0; i < NUM_FANS; i++) begin
                r_pwm[i] <= (r_pcnt < r_duty[i]);
                if (duty_load) r_tgt[i] <= clamp_tgt(duty_target[i*DUTY_W +: DUTY_W]);
                if (w_bnd) begin
                    if (force_full || (|r_fail)) r_duty[i] <= P_D;
                    else if (w_rstep)            r_duty[i] <= ramp_step(r_duty[i], r_tgt[i]);
                end

                r_ecnt[i] <= w_wend ? '0 : w_fin[i];
                if (w_wend) r_tcnt[i] <= w_fin[i];

                // Clear first so a simultaneous fail-setting window end overrides it.
                if (fail_clr) begin
                    r_fail[i] <= 1'b0;
                    r_low[i]  <= '0;
                end
                if (r_duty[i] == '0) begin
                    r_low[i] <= '0;
                end else if (w_wend) begin
                    if (w_fin[i] < TACH_W'(STALL_MIN)) begin
                        if (!fail_clr && r_low[i] != LCW'(FAIL_WINDOWS)) r_low[i] <= r_low[i] + 1'b1;
                        if (r_low[i] >= LCW'(FAIL_WINDOWS - 1)) r_fail[i] <= 1'b1;
                    end else begin
                        r_low[i] <= '0;
                    end
                end
            end
        end
    end

    assign pwm_out    = r_pwm;
    assign tach_valid = r_tvalid;
    assign fan_fail   = r_fail;

    always_comb begin
        duty_cur   = '0;
        tach_count = '0;
        for (int unsigned i = 0; i < NUM_FANS; i++) begin
            duty_cur[i*DUTY_W +: DUTY_W]   = r_duty[i];
            tach_count[i*TACH_W +: TACH_W] = r_tcnt[i];
        end
    end
endmodule

// File: tb/tb_fan_pwm_tach_ctrl.sv
// Directed bench for fan_pwm_tach_ctrl: small period/window so ramp, failsafe,
// stall and reset behaviour all fit in a few hundred cycles.
module tb_fan_pwm_tach_ctrl;
    localparam int NF = 3;
    localparam int DW = 8;
    localparam int TW = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [NF*DW-1:0]  duty_target;
    logic              duty_load, force_full, fail_clr;
    logic [NF-1:0]     tach_in;
    logic [NF-1:0]     pwm_out;
    logic [NF*DW-1:0]  duty_cur;
    logic [NF*TW-1:0]  tach_count;
    logic              tach_valid;
    logic [NF-1:0]     fan_fail;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int first_valid;
    bit tach_en = 1'b0;

    always #5 clk = ~clk;

    fan_pwm_tach_ctrl #(
        .NUM_FANS(NF), .DUTY_W(DW), .PERIOD(10), .RST_DUTY(150), .MIN_DUTY(4),
        .RAMP_DIV(1), .RAMP_STEP(2), .TACH_W(TW), .TACH_WIN(100),
        .STALL_MIN(2), .FAIL_WINDOWS(3)
    ) dut (
        .clk(clk), .rst(rst), .duty_target(duty_target), .duty_load(duty_load),
        .force_full(force_full), .fail_clr(fail_clr), .tach_in(tach_in),
        .pwm_out(pwm_out), .duty_cur(duty_cur), .tach_count(tach_count),
        .tach_valid(tach_valid), .fan_fail(fan_fail)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; cyc counts rising edges since the last reset release.
    // ch0 tach is a 20-cycle square wave: exactly 5 rising edges per 100 cycles.
    task automatic tick();
        @(negedge clk);
        cyc++;
        tach_in = {2'b00, (tach_en && ((cyc % 20) >= 10))};
    endtask

    task automatic ticks_to(input int c);
        while (cyc < c) tick();
    endtask

    function automatic logic [23:0] dv(input int a0, input int a1, input int a2);
        return {8'(a2), 8'(a1), 8'(a0)};
    endfunction

    task automatic run_period(input int ld_at, input int e0, input int e1, input int e2);
        int h0 = 0;
        int h1 = 0;
        int h2 = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            h0 += int'(pwm_out[0]);
            h1 += int'(pwm_out[1]);
            h2 += int'(pwm_out[2]);
            duty_load = (i == ld_at);
        end
        chk("pwm_hi0", h0, e0);
        chk("pwm_hi1", h1, e1);
        chk("pwm_hi2", h2, e2);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_pwm"},   pwm_out, 3'b000);
        chk({tag, "_duty"},  duty_cur, dv(10, 10, 10));
        chk({tag, "_tach"},  tach_count, 48'd0);
        chk({tag, "_valid"}, tach_valid, 1'b0);
        chk({tag, "_fail"},  fan_fail, 3'b000);
    endtask

    initial begin
        rst = 1'b1; duty_target = '0; duty_load = 1'b0; force_full = 1'b0;
        fail_clr = 1'b0; tach_in = '0;
        repeat (3) tick();
        chk_reset_state("rst0");

        rst = 1'b0; cyc = 0; tach_en = 1'b1;
        duty_target = dv(3, 3, 0);
        run_period(3, 10, 10, 10);   chk("duty_p1", duty_cur, dv(8, 8, 8));
        run_period(0, 8, 8, 8);      chk("duty_p2", duty_cur, dv(6, 6, 6));
        run_period(0, 6, 6, 6);      chk("duty_p3", duty_cur, dv(4, 4, 4));
        run_period(0, 4, 4, 4);      chk("duty_p4", duty_cur, dv(4, 4, 0));
        force_full = 1'b1;
        run_period(0, 4, 4, 0);      chk("duty_ff", duty_cur, dv(10, 10, 10));
        force_full = 1'b0;
        run_period(0, 10, 10, 10);   chk("duty_r1", duty_cur, dv(8, 8, 8));
        run_period(0, 8, 8, 8);      chk("duty_r2", duty_cur, dv(6, 6, 6));
        run_period(0, 6, 6, 6);      chk("duty_r3", duty_cur, dv(4, 4, 4));
        run_period(0, 4, 4, 4);      chk("duty_r4", duty_cur, dv(4, 4, 0));
        run_period(0, 4, 4, 0);

        chk("valid_w1", tach_valid, 1'b1);
        chk("tach0_w1", tach_count[15:0], 16'd5);
        chk("tach1_w1", tach_count[31:16], 16'd0);
        chk("fail_w1", fan_fail, 3'b000);

        duty_target = dv(3, 6, 0); duty_load = 1'b1;
        tick();
        duty_load = 1'b0;
        chk("valid_pulse", tach_valid, 1'b0);
        ticks_to(110);  chk("duty_ch1_6", duty_cur, dv(4, 6, 0));
        ticks_to(200);  chk("valid_w2", tach_valid, 1'b1);
                        chk("tach0_w2", tach_count[15:0], 16'd5);
        ticks_to(299);  chk("fail_pre", fan_fail, 3'b000);
        tick();         chk("fail_set", fan_fail, 3'b010);
                        chk("tach0_w3", tach_count[15:0], 16'd5);
        ticks_to(309);  chk("duty_pre_fs", duty_cur, dv(4, 6, 0));
        tick();         chk("duty_failsafe", duty_cur, dv(10, 10, 10));
        ticks_to(320);  chk("fail_sticky", fan_fail, 3'b010);
        fail_clr = 1'b1; tick(); fail_clr = 1'b0;
        chk("fail_clr", fan_fail, 3'b000);
        ticks_to(330);  chk("duty_release", duty_cur, dv(8, 8, 8));

        ticks_to(599);
        fail_clr = 1'b1; tick(); fail_clr = 1'b0;
        chk("fail_set_wins", fan_fail, 3'b010);
        ticks_to(610);  chk("duty_fs2", duty_cur, dv(10, 10, 10));
        ticks_to(620);
        fail_clr = 1'b1; tick(); fail_clr = 1'b0;
        ticks_to(635);  chk("duty_mid_ramp", duty_cur, dv(8, 8, 8));

        rst = 1'b1; tach_en = 1'b0;
        tick();
        chk_reset_state("rst1");
        rst = 1'b0; cyc = 0; tach_en = 1'b1;
        first_valid = -1;
        for (int i = 0; i < 150 && first_valid < 0; i++) begin
            tick();
            if (tach_valid === 1'b1) first_valid = cyc;
        end
        chk("first_valid_cyc", first_valid, 64'd100);
        chk("tach0_after_rst", tach_count[15:0], 16'd5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
